run_control_unit: RTL and testbench

//   Parametrised run/halt/debug controller at the MiniSRC top level, between the external reset/stop

---
 rtl/minisrc_pkg.sv | 25 ++
 rtl/bp_match.sv | 58 +++++
 rtl/run_control_unit.sv | 137 +++++++++++++
 tb/tb_run_control_unit.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/minisrc_pkg.sv
// Shared MiniSRC definitions: halt cause codes, run-control state encoding
// and the index-width helper used by breakpoint ports.
package minisrc_pkg;

  typedef enum logic [2:0] {
    CAUSE_NONE       = 3'd0,
    CAUSE_STOP       = 3'd1,
    CAUSE_HALT_INSTR = 3'd2,
    CAUSE_BREAK      = 3'd3,
    CAUSE_STEP       = 3'd4
  } halt_cause_e;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_STEP   = 2'd2,
    ST_HALTED = 2'd3
  } run_state_e;

  // A single-entry table still needs a 1-bit index port.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bp_match.sv
// PC breakpoint table: NUM_BP registered address/valid entries compared against
// pc_value; reports a hit and the lowest matching index.
module bp_match
  import minisrc_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int NUM_BP = 4,
  localparam int IDX_W = idx_width(NUM_BP)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              wr_valid,
  input  logic [ADDR_W-1:0] pc_value,
  output logic              hit,
  output logic [IDX_W-1:0]  idx
);

  logic [ADDR_W-1:0] addr_q [NUM_BP];
  logic [ADDR_W-1:0] addr_d [NUM_BP];
  logic [NUM_BP-1:0] valid_q;
  logic [NUM_BP-1:0] valid_d;

  always_comb begin
    addr_d  = addr_q;
    valid_d = valid_q;
    if (wr_en && (int'(wr_idx) < NUM_BP)) begin
      addr_d[wr_idx]  = wr_addr;
      valid_d[wr_idx] = wr_valid;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_BP; i++) addr_q[i] <= '0;
      valid_q <= '0;
    end else begin
      addr_q  <= addr_d;
      valid_q <= valid_d;
    end
  end

  // Compare reads the stored entries, so a same-cycle write is not yet visible.
  // Scanning downward lets the lowest matching index overwrite higher ones.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = NUM_BP - 1; i >= 0; i--) begin
      if (valid_q[i] && (addr_q[i] == pc_value)) begin
        hit = 1'b1;
        idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/run_control_unit.sv
// MiniSRC run/halt/debug controller: drives control_unit's Run enable, halts only
// at instruction boundaries (instr_done), and keeps breakpoints and counters.
module run_control_unit
  import minisrc_pkg::*;
#(
  parameter int ADDR_W        = 32,
  parameter int NUM_BP        = 4,
  parameter int CNT_W         = 32,
  parameter bit START_RUNNING = 1'b1,
  localparam int IDX_W        = idx_width(NUM_BP)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stop,
  input  logic              run_req,
  input  logic              step_req,
  input  logic              instr_done,
  input  logic              halt_instr,
  input  logic [ADDR_W-1:0] pc_value,
  input  logic              bp_wr_en,
  input  logic [IDX_W-1:0]  bp_wr_idx,
  input  logic [ADDR_W-1:0] bp_wr_addr,
  input  logic              bp_wr_valid,
  input  logic              cnt_clr,
  output logic              Run,
  output logic              halted,
  output logic [2:0]        halt_cause,
  output logic [IDX_W-1:0]  bp_hit_idx,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [CNT_W-1:0]  instr_count,
  output logic [1:0]        dbg_state
);

  // Control protocol: run_req, step_req and instr_done are single-cycle pulses
  // sampled on the rising edge with no back-pressure; stop is a level.
  localparam run_state_e RESET_STATE = START_RUNNING ? ST_RUN : ST_HALTED;

  run_state_e        state_q, state_d;
  halt_cause_e       cause_q, cause_d;
  logic [IDX_W-1:0]  bp_idx_q, bp_idx_d;
  logic [CNT_W-1:0]  cycle_q, cycle_d;
  logic [CNT_W-1:0]  instr_q, instr_d;
  logic              bp_hit;
  logic [IDX_W-1:0]  bp_idx;
  logic              active;

  bp_match #(
    .ADDR_W (ADDR_W),
    .NUM_BP (NUM_BP)
  ) u_bp_match (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (bp_wr_en),
    .wr_idx   (bp_wr_idx),
    .wr_addr  (bp_wr_addr),
    .wr_valid (bp_wr_valid),
    .pc_value (pc_value),
    .hit      (bp_hit),
    .idx      (bp_idx)
  );

  assign active = (state_q != ST_HALTED);

  always_comb begin
    state_d  = state_q;
    cause_d  = cause_q;
    bp_idx_d = bp_idx_q;
    case (state_q)
      ST_RUN, ST_DRAIN, ST_STEP: begin
        if (instr_done) begin
          state_d = ST_HALTED;
          if (halt_instr) begin
            cause_d = CAUSE_HALT_INSTR;
          end else if (bp_hit) begin
            cause_d  = CAUSE_BREAK;
            bp_idx_d = bp_idx;
          end else if (stop) begin
            cause_d = CAUSE_STOP;
          end else if (state_q == ST_STEP) begin
            cause_d = CAUSE_STEP;
          end else if (state_q == ST_DRAIN) begin
            cause_d = CAUSE_STOP;
          end else begin
            state_d = ST_RUN;
          end
        end else if ((state_q == ST_RUN) && stop) begin
          state_d = ST_DRAIN;
        end
      end
      ST_HALTED: begin
        // A halt instruction is terminal until reset.
        if (cause_q != CAUSE_HALT_INSTR) begin
          if (run_req)       state_d = ST_RUN;
          else if (step_req) state_d = ST_STEP;
        end
      end
    endcase
  end

  // Saturating counters; clear beats increment.
  always_comb begin
    cycle_d = cycle_q;
    instr_d = instr_q;
    if (cnt_clr) begin
      cycle_d = '0;
      instr_d = '0;
    end else begin
      if (active && (cycle_q != '1))               cycle_d = cycle_q + CNT_W'(1);
      if (active && instr_done && (instr_q != '1)) instr_d = instr_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= RESET_STATE;
      cause_q  <= CAUSE_NONE;
      bp_idx_q <= '0;
      cycle_q  <= '0;
      instr_q  <= '0;
    end else begin
      state_q  <= state_d;
      cause_q  <= cause_d;
      bp_idx_q <= bp_idx_d;
      cycle_q  <= cycle_d;
      instr_q  <= instr_d;
    end
  end

  assign Run         = active;
  assign halted      = ~active;
  assign halt_cause  = cause_q;
  assign bp_hit_idx  = bp_idx_q;
  assign cycle_count = cycle_q;
  assign instr_count = instr_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_run_control_unit.sv
// Directed bench for run_control_unit: a 32-bit-counter instance for control
// behaviour and a 4-bit-counter instance sharing inputs for saturation.
module tb_run_control_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stop = 1'b0, run_req = 1'b0, step_req = 1'b0;
  logic        instr_done = 1'b0, halt_instr = 1'b0;
  logic [31:0] pc_value = '0;
  logic        bp_wr_en = 1'b0;
  logic [1:0]  bp_wr_idx = '0;
  logic [31:0] bp_wr_addr = '0;
  logic        bp_wr_valid = 1'b0;
  logic        cnt_clr = 1'b0;

  logic        Run, halted;
  logic [2:0]  halt_cause;
  logic [1:0]  bp_hit_idx;
  logic [31:0] cycle_count, instr_count;
  logic [1:0]  dbg_state;

  logic        s_run, s_halted;
  logic [2:0]  s_cause;
  logic [1:0]  s_idx;
  logic [3:0]  s_cycle, s_instr;
  logic [1:0]  s_dbg;

  int n_tests = 0;
  int n_fail  = 0;

  run_control_unit #(.ADDR_W(32), .NUM_BP(4), .CNT_W(32), .START_RUNNING(1'b1)) dut (
    .clk(clk), .reset(reset), .stop(stop), .run_req(run_req), .step_req(step_req),
    .instr_done(instr_done), .halt_instr(halt_instr), .pc_value(pc_value),
    .bp_wr_en(bp_wr_en), .bp_wr_idx(bp_wr_idx), .bp_wr_addr(bp_wr_addr),
    .bp_wr_valid(bp_wr_valid), .cnt_clr(cnt_clr), .Run(Run), .halted(halted),
    .halt_cause(halt_cause), .bp_hit_idx(bp_hit_idx), .cycle_count(cycle_count),
    .instr_count(instr_count), .dbg_state(dbg_state)
  );

  run_control_unit #(.ADDR_W(32), .NUM_BP(4), .CNT_W(4), .START_RUNNING(1'b1)) dut_small (
    .clk(clk), .reset(reset), .stop(stop), .run_req(run_req), .step_req(step_req),
    .instr_done(instr_done), .halt_instr(halt_instr), .pc_value(pc_value),
    .bp_wr_en(bp_wr_en), .bp_wr_idx(bp_wr_idx), .bp_wr_addr(bp_wr_addr),
    .bp_wr_valid(bp_wr_valid), .cnt_clr(cnt_clr), .Run(s_run), .halted(s_halted),
    .halt_cause(s_cause), .bp_hit_idx(s_idx), .cycle_count(s_cycle),
    .instr_count(s_instr), .dbg_state(s_dbg)
  );

  // Clock / reset block: inputs change and outputs are sampled on the falling edge.
  initial forever #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick(); tick();
    n_tests++; if (Run !== 1'b1) begin n_fail++; $display("FAIL rst_run got=%0b exp=1", Run); end
    n_tests++; if (halted !== 1'b0) begin n_fail++; $display("FAIL rst_halted got=%0b exp=0", halted); end
    n_tests++; if (halt_cause !== 3'd0) begin n_fail++; $display("FAIL rst_cause got=%0d exp=0", halt_cause); end
    n_tests++; if (bp_hit_idx !== 2'd0) begin n_fail++; $display("FAIL rst_bpidx got=%0d exp=0", bp_hit_idx); end
    n_tests++; if (cycle_count !== 32'd0) begin n_fail++; $display("FAIL rst_cycle got=%0d exp=0", cycle_count); end
    n_tests++; if (instr_count !== 32'd0) begin n_fail++; $display("FAIL rst_instr got=%0d exp=0", instr_count); end
    reset = 1'b1;
    tick();
    n_tests++; if (Run !== 1'b1) begin n_fail++; $display("FAIL rel_run got=%0b exp=1", Run); end
    n_tests++; if (halted !== 1'b0) begin n_fail++; $display("FAIL rel_halted got=%0b exp=0", halted); end
    n_tests++; if (halt_cause !== 3'd0) begin n_fail++; $display("FAIL rel_cause got=%0d exp=0", halt_cause); end
    n_tests++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL rel_state got=%0d exp=0", dbg_state); end
    repeat (9) tick();
    n_tests++; if (cycle_count !== 32'd10) begin n_fail++; $display("FAIL cycle10 got=%0d exp=10", cycle_count); end
    n_tests++; if (s_cycle !== 4'hA) begin n_fail++; $display("FAIL s_cycle10 got=%0h exp=a", s_cycle); end
  endtask

  task automatic test_counter_sat();
    repeat (10) tick();
    n_tests++; if (cycle_count !== 32'd20) begin n_fail++; $display("FAIL cycle20 got=%0d exp=20", cycle_count); end
    n_tests++; if (s_cycle !== 4'hF) begin n_fail++; $display("FAIL s_cycle_sat got=%0h exp=f", s_cycle); end
    repeat (3) tick();
    n_tests++; if (s_cycle !== 4'hF) begin n_fail++; $display("FAIL s_cycle_hold got=%0h exp=f", s_cycle); end
    cnt_clr = 1'b1; instr_done = 1'b1; pc_value = 32'h100;
    tick();
    cnt_clr = 1'b0; instr_done = 1'b0;
    n_tests++; if (cycle_count !== 32'd0) begin n_fail++; $display("FAIL clr_cycle got=%0d exp=0", cycle_count); end
    n_tests++; if (instr_count !== 32'd0) begin n_fail++; $display("FAIL clr_instr got=%0d exp=0", instr_count); end
    n_tests++; if (s_cycle !== 4'h0) begin n_fail++; $display("FAIL s_clr_cycle got=%0h exp=0", s_cycle); end
    n_tests++; if (Run !== 1'b1) begin n_fail++; $display("FAIL clr_run got=%0b exp=1", Run); end
    tick();
    n_tests++; if (cycle_count !== 32'd1) begin n_fail++; $display("FAIL post_clr_cycle got=%0d exp=1", cycle_count); end
  endtask

  task automatic test_stop();
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0; stop = 1'b1;
    tick();
    n_tests++; if (Run !== 1'b1) begin n_fail++; $display("FAIL drain_run got=%0b exp=1", Run); end
    n_tests++; if (dbg_state !== 2'd1) begin n_fail++; $display("FAIL drain_state got=%0d exp=1", dbg_state); end
    tick();
    n_tests++; if (halted !== 1'b0) begin n_fail++; $display("FAIL drain_halted got=%0b exp=0", halted); end
    instr_done = 1'b1; pc_value = 32'h104;
    tick();
    instr_done = 1'b0;
    n_tests++; if (Run !== 1'b0) begin n_fail++; $display("FAIL stop_run got=%0b exp=0", Run); end
    n_tests++; if (halted !== 1'b1) begin n_fail++; $display("FAIL stop_halted got=%0b exp=1", halted); end
    n_tests++; if (halt_cause !== 3'd1) begin n_fail++; $display("FAIL stop_cause got=%0d exp=1", halt_cause); end
    n_tests++; if (instr_count !== 32'd1) begin n_fail++; $display("FAIL stop_instr got=%0d exp=1", instr_count); end
    n_tests++; if (cycle_count !== 32'd3) begin n_fail++; $display("FAIL stop_cycle got=%0d exp=3", cycle_count); end
    instr_done = 1'b1;
    tick();
    instr_done = 1'b0;
    tick();
    n_tests++; if (instr_count !== 32'd1) begin n_fail++; $display("FAIL halted_instr got=%0d exp=1", instr_count); end
    n_tests++; if (cycle_count !== 32'd3) begin n_fail++; $display("FAIL halted_cycle got=%0d exp=3", cycle_count); end
    n_tests++; if (Run !== 1'b0) begin n_fail++; $display("FAIL halted_stop_run got=%0b exp=0", Run); end
  endtask

  task automatic test_resume_with_stop();
    run_req = 1'b1;
    tick();
    run_req = 1'b0;
    n_tests++; if (Run !== 1'b1) begin n_fail++; $display("FAIL rs_run got=%0b exp=1", Run); end
    n_tests++; if (halt_cause !== 3'd1) begin n_fail++; $display("FAIL rs_cause_kept got=%0d exp=1", halt_cause); end
    tick();
    n_tests++; if (Run !== 1'b1) begin n_fail++; $display("FAIL rs_drain_run got=%0b exp=1", Run); end
    instr_done = 1'b1; pc_value = 32'h108;
    tick();
    instr_done = 1'b0;
    n_tests++; if (Run !== 1'b0) begin n_fail++; $display("FAIL rs_halt_run got=%0b exp=0", Run); end
    n_tests++; if (halt_cause !== 3'd1) begin n_fail++; $display("FAIL rs_halt_cause got=%0d exp=1", halt_cause); end
    n_tests++; if (instr_count !== 32'd2) begin n_fail++; $display("FAIL rs_instr got=%0d exp=2", instr_count); end
    stop = 1'b0;
  endtask

  task automatic test_step();
    step_req = 1'b1;
    tick();
    step_req = 1'b0;
    n_tests++; if (Run !== 1'b1) begin n_fail++; $display("FAIL step_run got=%0b exp=1", Run); end
    n_tests++; if (dbg_state !== 2'd2) begin n_fail++; $display("FAIL step_state got=%0d exp=2", dbg_state); end
    n_tests++; if (halt_cause !== 3'd1) begin n_fail++; $display("FAIL step_cause_kept got=%0d exp=1", halt_cause); end
    tick();
    instr_done = 1'b1; pc_value = 32'h10C;
    tick();
    instr_done = 1'b0;
    n_tests++; if (Run !== 1'b0) begin n_fail++; $display("FAIL step_done_run got=%0b exp=0", Run); end
    n_tests++; if (halt_cause !== 3'd4) begin n_fail++; $display("FAIL step_cause got=%0d exp=4", halt_cause); end
    n_tests++; if (instr_count !== 32'd3) begin n_fail++; $display("FAIL step_instr got=%0d exp=3", instr_count); end
    tick();
    n_tests++; if (halted !== 1'b1) begin n_fail++; $display("FAIL step_stays got=%0b exp=1", halted); end
    run_req = 1'b1; step_req = 1'b1;
    tick();
    run_req = 1'b0; step_req = 1'b0;
    tick();
    n_tests++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL both_req_state got=%0d exp=0", dbg_state); end
    n_tests++; if (Run !== 1'b1) begin n_fail++; $display("FAIL both_req_run got=%0b exp=1", Run); end
  endtask

  task automatic bp_write(input logic [1:0] idx, input logic [31:0] addr, input logic vld);
    bp_wr_en = 1'b1; bp_wr_idx = idx; bp_wr_addr = addr; bp_wr_valid = vld;
    tick();
    bp_wr_en = 1'b0;
  endtask

  task automatic resume();
    run_req = 1'b1;
    tick();
    run_req = 1'b0;
  endtask

  task automatic test_breakpoint();
    bp_write(2'd0, 32'h20, 1'b1);
    bp_write(2'd1, 32'h24, 1'b1);
    bp_write(2'd2, 32'h24, 1'b1);
    instr_done = 1'b1; pc_value = 32'h20;
    tick();
    instr_done = 1'b0;
    n_tests++; if (Run !== 1'b0) begin n_fail++; $display("FAIL bp0_run got=%0b exp=0", Run); end
    n_tests++; if (halt_cause !== 3'd3) begin n_fail++; $display("FAIL bp0_cause got=%0d exp=3", halt_cause); end
    n_tests++; if (bp_hit_idx !== 2'd0) begin n_fail++; $display("FAIL bp0_idx got=%0d exp=0", bp_hit_idx); end
    resume();
    instr_done = 1'b1; pc_value = 32'h24;
    tick();
    instr_done = 1'b0;
    n_tests++; if (halt_cause !== 3'd3) begin n_fail++; $display("FAIL bp12_cause got=%0d exp=3", halt_cause); end
    n_tests++; if (bp_hit_idx !== 2'd1) begin n_fail++; $display("FAIL bp12_idx got=%0d exp=1", bp_hit_idx); end
    resume();
    instr_done = 1'b1; pc_value = 32'h28;
    bp_wr_en = 1'b1; bp_wr_idx = 2'd3; bp_wr_addr = 32'h28; bp_wr_valid = 1'b1;
    tick();
    instr_done = 1'b0; bp_wr_en = 1'b0;
    n_tests++; if (Run !== 1'b1) begin n_fail++; $display("FAIL wr_vs_cmp_run got=%0b exp=1", Run); end
    instr_done = 1'b1;
    tick();
    instr_done = 1'b0;
    n_tests++; if (Run !== 1'b0) begin n_fail++; $display("FAIL bp3_run got=%0b exp=0", Run); end
    n_tests++; if (bp_hit_idx !== 2'd3) begin n_fail++; $display("FAIL bp3_idx got=%0d exp=3", bp_hit_idx); end
    bp_write(2'd3, 32'h28, 1'b0);
    resume();
    instr_done = 1'b1;
    tick();
    instr_done = 1'b0;
    n_tests++; if (Run !== 1'b1) begin n_fail++; $display("FAIL bp_invalid_run got=%0b exp=1", Run); end
  endtask

  task automatic test_halt_instr();
    instr_done = 1'b1; halt_instr = 1'b1; pc_value = 32'h20;
    tick();
    instr_done = 1'b0; halt_instr = 1'b0;
    n_tests++; if (Run !== 1'b0) begin n_fail++; $display("FAIL hi_run got=%0b exp=0", Run); end
    n_tests++; if (halt_cause !== 3'd2) begin n_fail++; $display("FAIL hi_cause got=%0d exp=2", halt_cause); end
    n_tests++; if (bp_hit_idx !== 2'd3) begin n_fail++; $display("FAIL hi_idx_kept got=%0d exp=3", bp_hit_idx); end
    run_req = 1'b1;
    tick();
    run_req = 1'b0;
    tick();
    n_tests++; if (Run !== 1'b0) begin n_fail++; $display("FAIL hi_run_req got=%0b exp=0", Run); end
    step_req = 1'b1;
    tick();
    step_req = 1'b0;
    tick();
    n_tests++; if (Run !== 1'b0) begin n_fail++; $display("FAIL hi_step_req got=%0b exp=0", Run); end
    n_tests++; if (halt_cause !== 3'd2) begin n_fail++; $display("FAIL hi_sticky got=%0d exp=2", halt_cause); end
    reset = 1'b0;
    #1;
    n_tests++; if (Run !== 1'b1) begin n_fail++; $display("FAIL hi_async_run got=%0b exp=1", Run); end
    n_tests++; if (halt_cause !== 3'd0) begin n_fail++; $display("FAIL hi_async_cause got=%0d exp=0", halt_cause); end
    n_tests++; if (bp_hit_idx !== 2'd0) begin n_fail++; $display("FAIL hi_async_idx got=%0d exp=0", bp_hit_idx); end
    n_tests++; if (cycle_count !== 32'd0) begin n_fail++; $display("FAIL hi_async_cycle got=%0d exp=0", cycle_count); end
    tick();
    reset = 1'b1;
    tick();
    instr_done = 1'b1; pc_value = 32'h20;
    tick();
    instr_done = 1'b0;
    n_tests++; if (Run !== 1'b1) begin n_fail++; $display("FAIL bp_cleared_run got=%0b exp=1", Run); end
  endtask

  initial begin
    test_reset();
    test_counter_sat();
    test_stop();
    test_resume_with_stop();
    test_step();
    test_breakpoint();
    test_halt_instr();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
